// File: rtl/dsp_delay_pkg.sv
// Shared definitions for the delay measurement block: FSM encoding,
// counter width helper and the legal DELAY_SHIFT range.
package dsp_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } meas_state_e;

    localparam int unsigned RESULT_W        = 16;
    localparam int unsigned DELAY_SHIFT_MIN = 0;
    localparam int unsigned DELAY_SHIFT_MAX = 16;

    // Raw counter needs DELAY_SHIFT extra bits so the shifted result still spans 16 bits.
    function automatic int unsigned calc_cw(input int unsigned delay_shift);
        return RESULT_W + delay_shift;
    endfunction

endpackage

// File: rtl/delay_meas_counter.sv
// Saturating up-counter with synchronous clear. The next-state count and
// saturation flag are exported so the parent can capture them on the same edge.
module delay_meas_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          enable_i,
    output logic [CW-1:0] count_next_o,
    output logic          sat_next_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          sat_q;
    logic          sat_d;

    // Next count: clear wins over enable; hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clear_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (enable_i && !(&count_q)) begin
                count_d = count_q + 1'b1;
            end
            sat_d = sat_q | (&count_d);
        end
    end

    // Count and sticky saturation registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_next_o = count_d;
    assign sat_next_o   = sat_d;

endmodule

// File: rtl/dsp_delay_measure.sv
// Measures enabled-cycle interval between a start and a stop event and
// returns it, scaled down by DELAY_SHIFT, over a valid/ready handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; counter held clear
// ST_COUNT | counting enabled cycles; stop captures the result
// ST_DONE  | result presented on valid_o until ready_i accepts it
module dsp_delay_measure
    import dsp_delay_pkg::*;
#(
    parameter int unsigned DELAY_SHIFT = 0,
    parameter string       SYNC_EVENTS = "TRUE"
) (
    input  logic                fast_clk_i,
    input  logic                fast_rst_n_i,
    input  logic                count_enable_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                busy_o,
    output logic [RESULT_W-1:0] delay_o,
    output logic                overflow_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int unsigned CW = calc_cw(DELAY_SHIFT);

    if (DELAY_SHIFT > DELAY_SHIFT_MAX) begin : g_bad_shift
        $error("dsp_delay_measure: DELAY_SHIFT out of range");
    end

    meas_state_e         state_q, state_d;
    logic                start_ev, stop_ev;
    logic                cnt_clear, cnt_en, capture;
    logic [CW-1:0]       count_next;
    logic                sat_next;
    logic [RESULT_W-1:0] delay_q;
    logic                overflow_q, valid_q, busy_q;

    if (SYNC_EVENTS == "TRUE") begin : g_sync
        logic start_q, stop_q;

        // One register stage on both events keeps the measured interval unchanged.
        always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
            if (!fast_rst_n_i) begin
                start_q <= 1'b0;
                stop_q  <= 1'b0;
            end else begin
                start_q <= start_i;
                stop_q  <= stop_i;
            end
        end

        assign start_ev = start_q;
        assign stop_ev  = stop_q;
    end else begin : g_direct
        assign start_ev = start_i;
        assign stop_ev  = stop_i;
    end

    // State register.
    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; events outside their own state are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ev) state_d = ST_COUNT;
            ST_COUNT: if (stop_ev)  state_d = ST_DONE;
            ST_DONE:  if (ready_i)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter control: clear while idle so the accept cycle is never counted.
    always_comb begin
        cnt_clear = (state_q == ST_IDLE);
        cnt_en    = (state_q == ST_COUNT) && count_enable_i;
        capture   = (state_q == ST_COUNT) && stop_ev;
    end

    delay_meas_counter #(
        .CW (CW)
    ) u_counter (
        .clk_i        (fast_clk_i),
        .rst_n_i      (fast_rst_n_i),
        .clear_i      (cnt_clear),
        .enable_i     (cnt_en),
        .count_next_o (count_next),
        .sat_next_o   (sat_next)
    );

    // Result and status registers; capture includes the stop-cycle increment.
    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            delay_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (capture) begin
                delay_q    <= RESULT_W'(count_next >> DELAY_SHIFT);
                overflow_q <= sat_next;
            end
            valid_q <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign busy_o     = busy_q;
    assign delay_o    = delay_q;
    assign overflow_o = overflow_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_dsp_delay_measure.sv
// Scoreboard bench: three instances (shift 0 direct, shift 4 synced,
// shift 2 synced) share stimulus; expected results are queued per instance
// and checked by a monitor whenever valid_o rises.
module tb_dsp_delay_measure;

    typedef struct {
        logic [15:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, start, stop_drv, stop, ready;
    logic        use_model, mrst_n, reached;
    logic [7:0]  mcnt;
    logic        en_alt;
    logic        busy  [3];
    logic [15:0] dly   [3];
    logic        ovf   [3];
    logic        valid [3];
    logic        vprev [3];
    exp_t        q0[$], q1[$], q2[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign stop = stop_drv | (use_model & reached);

    dsp_delay_measure #(.DELAY_SHIFT(0), .SYNC_EVENTS("FALSE")) u_d0 (
        .fast_clk_i(clk), .fast_rst_n_i(rst_n), .count_enable_i(en),
        .start_i(start), .stop_i(stop), .busy_o(busy[0]), .delay_o(dly[0]),
        .overflow_o(ovf[0]), .valid_o(valid[0]), .ready_i(ready));

    dsp_delay_measure #(.DELAY_SHIFT(4), .SYNC_EVENTS("TRUE")) u_d4 (
        .fast_clk_i(clk), .fast_rst_n_i(rst_n), .count_enable_i(en),
        .start_i(start), .stop_i(stop), .busy_o(busy[1]), .delay_o(dly[1]),
        .overflow_o(ovf[1]), .valid_o(valid[1]), .ready_i(ready));

    dsp_delay_measure #(.DELAY_SHIFT(2), .SYNC_EVENTS("TRUE")) u_d2 (
        .fast_clk_i(clk), .fast_rst_n_i(rst_n), .count_enable_i(en),
        .start_i(start), .stop_i(stop), .busy_o(busy[2]), .delay_o(dly[2]),
        .overflow_o(ovf[2]), .valid_o(valid[2]), .ready_i(ready));

    // Behavioural stand-in for dsp_delay with DELAY_SHIFT=2, delay_i=25: 100 enabled cycles.
    always @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            mcnt    <= '0;
            reached <= 1'b0;
        end else if (!reached && en) begin
            mcnt <= mcnt + 8'd1;
            if (mcnt + 8'd1 == 8'd100) reached <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d0, input logic o0, input logic [15:0] d4,
                        input logic o4, input logic [15:0] d2, input logic o2);
        q0.push_back('{d0, o0});
        q1.push_back('{d4, o4});
        q2.push_back('{d2, o2});
    endtask

    task automatic pop_check(input int i);
        exp_t e;
        bit   got;
        got = 1'b0;
        e   = '{16'h0, 1'b0};
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_result dut%0d: got delay %0d, none expected", i, dly[i]);
        end else begin
            chk($sformatf("sb_delay dut%0d", i), 32'(dly[i]), 32'(e.d));
            chk($sformatf("sb_overflow dut%0d", i), 32'(ovf[i]), 32'(e.o));
        end
    endtask

    // Monitor: compare against the scoreboard on each rising valid_o.
    initial for (int i = 0; i < 3; i++) vprev[i] = 1'b0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i] && !vprev[i]) pop_check(i);
            vprev[i] = valid[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (en_alt) en = ~en;
    endtask

    // Start accepted at one edge, stop seen n edges later.
    task automatic measure(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (n - 1) tick();
        stop_drv = 1'b1;
        tick();
        stop_drv = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s valid dut%0d", tag, i), 32'(valid[i]), 32'd0);
            chk($sformatf("%s busy dut%0d", tag, i), 32'(busy[i]), 32'd0);
            chk($sformatf("%s delay dut%0d", tag, i), 32'(dly[i]), 32'd0);
            chk($sformatf("%s overflow dut%0d", tag, i), 32'(ovf[i]), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; stop_drv = 1'b0; ready = 1'b1;
        use_model = 1'b0; mrst_n = 1'b0; en_alt = 1'b0;
        #1;
        chk_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // 1: 100 enabled cycles, with stop-to-valid latency checks.
        push(16'd100, 1'b0, 16'd6, 1'b0, 16'd25, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1 busy after start", 32'(busy[0]), 32'd1);
        repeat (99) tick();
        stop_drv = 1'b1;
        chk("t1 valid before stop edge", 32'(valid[0]), 32'd0);
        tick();
        stop_drv = 1'b0;
        chk("t1 valid one cycle after stop", 32'(valid[0]), 32'd1);
        chk("t1 synced valid not yet", 32'(valid[1]), 32'd0);
        tick();
        chk("t1 synced valid after two cycles", 32'(valid[1]), 32'd1);
        repeat (4) tick();

        // 2: enable every other cycle, 200 enabled cycles in the window.
        push(16'd200, 1'b0, 16'd12, 1'b0, 16'd50, 1'b0);
        en_alt = 1'b1;
        measure(400);
        repeat (4) tick();
        en_alt = 1'b0;
        en = 1'b1;
        repeat (2) tick();

        // 3: saturation on the shift-0 instance, no wrap.
        push(16'hFFFF, 1'b1, 16'd4375, 1'b0, 16'd17500, 1'b0);
        measure(70000);
        repeat (4) tick();

        // 4: result held while ready is low, events ignored in DONE.
        ready = 1'b0;
        push(16'd37, 1'b0, 16'd2, 1'b0, 16'd9, 1'b0);
        measure(37);
        repeat (2) tick();
        for (int k = 0; k < 20; k++) begin
            if (k == 5 || k == 15) start = 1'b1;
            if (k == 10 || k == 15) stop_drv = 1'b1;
            tick();
            start = 1'b0;
            stop_drv = 1'b0;
            chk("t4 hold delay dut0", 32'(dly[0]), 32'd37);
            chk("t4 hold delay dut4", 32'(dly[1]), 32'd2);
            chk("t4 hold delay dut2", 32'(dly[2]), 32'd9);
            chk("t4 hold valid dut0", 32'(valid[0]), 32'd1);
            chk("t4 hold valid dut4", 32'(valid[1]), 32'd1);
            chk("t4 hold valid dut2", 32'(valid[2]), 32'd1);
        end
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4 valid after handshake", 32'(valid[0]), 32'd0);
        chk("t4 busy after handshake", 32'(busy[0]), 32'd0);
        chk("t4 delay held after handshake", 32'(dly[0]), 32'd37);
        tick();
        chk("t4 start in handshake ignored", 32'(busy[0]), 32'd0);

        // 5: asynchronous reset mid-count, then a fresh measurement of 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("t5 busy before reset", 32'(busy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5 async reset");
        tick();
        rst_n = 1'b1;
        tick();
        push(16'd5, 1'b0, 16'd0, 1'b0, 16'd1, 1'b0);
        measure(5);
        repeat (4) tick();

        // 6: round trip against the dsp_delay stand-in.
        push(16'd100, 1'b0, 16'd6, 1'b0, 16'd25, 1'b0);
        mrst_n = 1'b1;
        use_model = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (105) tick();
        use_model = 1'b0;
        mrst_n = 1'b0;
        repeat (4) tick();

        chk("sb pending dut0", 32'(q0.size()), 32'd0);
        chk("sb pending dut4", 32'(q1.size()), 32'd0);
        chk("sb pending dut2", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_delay_measure.md
Name: dsp_delay_measure

Overview:
- Measures the interval that dsp_delay generates. It counts count_enable_i-qualified cycles between a start event and a stop event.
- It reports the count in the same units as dsp_delay's delay_i, i.e. right-shifted by DELAY_SHIFT.
- Used in the fast clock domain to calibrate and self-check programmed delays. Also used to time external trigger-to-response intervals.
- The result is returned over a valid/ready handshake to slower control logic.

Parameters:
- DELAY_SHIFT, 0: result = raw count >> DELAY_SHIFT. Matches dsp_delay DELAY_SHIFT. Legal range 0..16.
- SYNC_EVENTS, "TRUE": "TRUE" registers start_i/stop_i once before use, adding 1 cycle of event latency. "FALSE" uses them directly.

Ports:
- fast_clk_i  input  1  single clock for the block.
- fast_rst_n_i  input  1  reset, asynchronous assert, active-low.
- count_enable_i  input  1  qualifies counting. Same meaning as dsp_delay count_enable_i.
- start_i  input  1  level sampled each cycle; accepted only in IDLE.
- stop_i  input  1  level sampled each cycle; accepted only in COUNT.
- busy_o  output  1  high in COUNT or DONE.
- delay_o  output  16  measured delay, held stable while valid_o=1.
- overflow_o  output  1  saturation flag qualified by valid_o.
- valid_o  output  1  result available.
- ready_i  input  1  consumer accepts result when valid_o & ready_i.

Behaviour:
- Reset (fast_rst_n_i=0, asynchronous):
  - state=IDLE, raw counter=0.
  - delay_o=0, overflow_o=0, valid_o=0, busy_o=0.
  - Event pipeline registers=0.
- Raw counter:
  - Width CW=16+DELAY_SHIFT bits, unsigned.
  - Saturates at all-ones and never wraps. Hitting all-ones sets an internal sat flag.
- States: IDLE, COUNT, DONE. "ev" below means start_i/stop_i after the optional SYNC_EVENTS register.
- IDLE:
  - start ev=1 → COUNT; counter←0; sat←0.
  - count_enable_i in the accept cycle is NOT counted.
  - stop ev ignored.
- COUNT:
  - Each cycle with count_enable_i=1: counter←counter+1, saturating.
  - stop ev=1 → DONE. count_enable_i in the stop cycle IS counted, so result = number of enabled cycles in (start, stop].
  - Capture in the same edge:
    - delay_o ← (counter_next >> DELAY_SHIFT)[15:0], where counter_next includes the stop-cycle increment.
    - overflow_o ← sat_next.
    - valid_o←1.
  - start ev ignored (no restart).
  - start and stop both high in IDLE: start accepted, stop ignored that cycle.
- DONE:
  - valid_o=1; delay_o and overflow_o frozen.
  - valid_o & ready_i → IDLE, valid_o←0 next cycle. delay_o holds last value.
  - start ev in the handshake cycle is ignored; the next start is accepted from IDLE only.
  - start/stop otherwise ignored.
- Latency:
  - stop ev to valid_o: 1 cycle.
  - With SYNC_EVENTS="TRUE", stop_i to valid_o: 2 cycles, and start_i is also delayed 1 cycle, so the measured interval is unchanged.
- busy_o is registered and equals (state!=IDLE).
- Reset mid-COUNT or mid-DONE: immediate return to reset values; pending result discarded.
- Round-trip requirement: dsp_delay counts D<<DELAY_SHIFT enabled cycles before count_reached_o. Using its reset release as start and count_reached_o as stop, with identical count_enable_i, this block reports D.
- All counter logic is fabric. No DSP48 primitive is required.

Decomposition:
- Package dsp_delay_pkg holds:
  - the state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2);
  - localparam CW function of DELAY_SHIFT;
  - the DELAY_SHIFT legality range.
- Sub-module delay_meas_counter:
  - CW-bit saturating up-counter with clear, enable and sat output;
  - also provides counter_next and sat_next for same-edge capture.
- FSM, event pipeline and handshake live in dsp_delay_measure.

Test Plan:
1. DELAY_SHIFT=0, SYNC_EVENTS="FALSE"; start at cycle 10, count_enable_i=1 continuously, stop at cycle 110 → delay_o=100, overflow_o=0, valid_o rises at cycle 111.
2. DELAY_SHIFT=4; count_enable_i high every other cycle; start, then stop after 200 enabled cycles → delay_o=12 (200>>4), overflow_o=0.
3. DELAY_SHIFT=0; enable always on; stop withheld for 70000 cycles → delay_o=16'hFFFF, overflow_o=1, no wrap.
4. Handshake: result 37 with ready_i=0 for 20 cycles, plus start_i and stop_i pulses during the wait → delay_o stays 37 and valid_o stays 1. ready_i=1 → valid_o=0 next cycle, busy_o=0. A start in the handshake cycle is ignored.
5. Reset mid-COUNT: fast_rst_n_i low asynchronously between clock edges → valid_o, busy_o and delay_o go to 0 immediately. After release, a fresh measurement of 5 reports 5.
6. Round trip: dsp_delay (DELAY_SHIFT=2, delay_i=25) in parallel; start on its reset release, stop on count_reached_o → delay_o=25.
